// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream raster test-pattern source: SOF on tuser, EOL on tlast, optional
// horizontal/vertical blanking, four selectable patterns latched per frame.
module axis_video_pattern_gen #(
  parameter int WIDTH       = 1920,
  parameter int HEIGHT      = 1080,
  parameter int DATA_WIDTH  = 24,
  parameter int COORD_WIDTH = 16,
  parameter int HBLANK      = 0,
  parameter int VBLANK      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  localparam logic [COORD_WIDTH-1:0] X_LAST   = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST   = COORD_WIDTH'(HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] BAR_LAST = COORD_WIDTH'(WIDTH / 8 - 1);
  localparam logic [15:0]            HB_LOAD  = (HBLANK > 0) ? 16'(HBLANK - 1) : 16'd0;
  localparam logic [15:0]            VB_LOAD  = (VBLANK > 0) ? 16'(VBLANK - 1) : 16'd0;

  state_t                 state, state_nx;
  logic [COORD_WIDTH-1:0] x, x_nx, y, y_nx, bar_c, barc_nx;
  logic [2:0]             bar_i, bari_nx;
  logic [15:0]            blank_cnt, blank_nx, cnt_nx;
  logic [1:0]             pat, pat_nx;
  logic [7:0]             fc_lat, fclat_nx;
  logic                   present, done_nx, start;
  logic [DATA_WIDTH-1:0]  tdata_nx;
  logic                   tvalid_nx, tuser_nx, tlast_nx, busy_nx;

  function automatic logic [DATA_WIDTH-1:0] pixel(
    input logic [1:0] p, input logic [COORD_WIDTH-1:0] px, input logic [COORD_WIDTH-1:0] py,
    input logic [2:0] bar, input logic [7:0] fc);
    logic [23:0] c;
    case (p)
      2'd0: begin
        case (bar)
          3'd0:    c = 24'hFFFFFF;
          3'd1:    c = 24'hFFFF00;
          3'd2:    c = 24'h00FFFF;
          3'd3:    c = 24'h00FF00;
          3'd4:    c = 24'hFF00FF;
          3'd5:    c = 24'hFF0000;
          3'd6:    c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      2'd1:    c = {px[7:0], px[7:0], px[7:0]};
      2'd2:    c = (px[4:0] == 5'd0 || py[4:0] == 5'd0 || px == X_LAST || py == Y_LAST)
                   ? 24'hFFFFFF : 24'h000000;
      default: c = {px[7:0], py[7:0], fc};
    endcase
    return DATA_WIDTH'(c);
  endfunction

  wire hs  = m_axis_tvalid && m_axis_tready;
  wire eol = (x == X_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      bar_c         <= '0;
      bar_i         <= '0;
      blank_cnt     <= '0;
      pat           <= '0;
      fc_lat        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      x             <= x_nx;
      y             <= y_nx;
      bar_c         <= barc_nx;
      bar_i         <= bari_nx;
      blank_cnt     <= blank_nx;
      pat           <= pat_nx;
      fc_lat        <= fclat_nx;
      m_axis_tdata  <= tdata_nx;
      m_axis_tvalid <= tvalid_nx;
      m_axis_tuser  <= tuser_nx;
      m_axis_tlast  <= tlast_nx;
      frame_done    <= done_nx;
      frame_cnt     <= cnt_nx;
      busy          <= busy_nx;
    end
  end

  // Next-state: 'present' means a fresh pixel at (x_nx, y_nx) is shown next cycle.
  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    barc_nx  = bar_c;
    bari_nx  = bar_i;
    blank_nx = blank_cnt;
    pat_nx   = pat;
    fclat_nx = fc_lat;
    cnt_nx   = frame_cnt;
    present  = 1'b0;
    done_nx  = 1'b0;
    start    = 1'b0;
    case (state)
      S_IDLE: start = enable;
      S_ACTIVE: begin
        if (hs) begin
          if (!eol) begin
            x_nx    = x + 1'b1;
            present = 1'b1;
            if (bar_c == BAR_LAST) begin
              barc_nx = '0;
              bari_nx = (bar_i == 3'd7) ? 3'd7 : bar_i + 3'd1;
            end else begin
              barc_nx = bar_c + 1'b1;
            end
          end else if (y != Y_LAST) begin
            x_nx    = '0;
            y_nx    = y + 1'b1;
            barc_nx = '0;
            bari_nx = '0;
            if (HBLANK > 0) begin
              state_nx = S_HBLANK;
              blank_nx = HB_LOAD;
            end else begin
              present = 1'b1;
            end
          end else begin
            done_nx = 1'b1;
            cnt_nx  = frame_cnt + 16'd1;
            if (VBLANK > 0) begin
              state_nx = S_VBLANK;
              blank_nx = VB_LOAD;
            end else if (enable) begin
              start = 1'b1;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
      end
      S_HBLANK: begin
        if (blank_cnt == 16'd0) begin
          state_nx = S_ACTIVE;
          present  = 1'b1;
        end else begin
          blank_nx = blank_cnt - 16'd1;
        end
      end
      default: begin
        if (blank_cnt == 16'd0) begin
          if (enable) start = 1'b1;
          else        state_nx = S_IDLE;
        end else begin
          blank_nx = blank_cnt - 16'd1;
        end
      end
    endcase
    if (start) begin
      state_nx = S_ACTIVE;
      x_nx     = '0;
      y_nx     = '0;
      barc_nx  = '0;
      bari_nx  = '0;
      pat_nx   = pattern_sel;
      fclat_nx = cnt_nx[7:0];
      present  = 1'b1;
    end
  end

  // Output values registered next edge; a stalled beat simply holds.
  always_comb begin
    tvalid_nx = (state_nx == S_ACTIVE);
    busy_nx   = (state_nx != S_IDLE);
    tdata_nx  = '0;
    tuser_nx  = 1'b0;
    tlast_nx  = 1'b0;
    if (present) begin
      tdata_nx = pixel(pat_nx, x_nx, y_nx, bari_nx, fclat_nx);
      tuser_nx = (x_nx == '0) && (y_nx == '0);
      tlast_nx = (x_nx == X_LAST);
    end else if (tvalid_nx) begin
      tdata_nx = m_axis_tdata;
      tuser_nx = m_axis_tuser;
      tlast_nx = m_axis_tlast;
    end
  end

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Scoreboard bench for axis_video_pattern_gen: stimulus queues expected beats
// from a frame-level model, a negedge monitor pops and compares on handshakes.
module tb_axis_video_pattern_gen;
  localparam int W  = 16;
  localparam int H  = 4;
  localparam int HB = 2;
  localparam int VB = 3;

  logic        clk = 1'b0;
  logic        rst_n, enable, m_axis_tready;
  logic [1:0]  pattern_sel;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done, busy;
  logic [15:0] frame_cnt;

  axis_video_pattern_gen #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(24), .COORD_WIDTH(16), .HBLANK(HB), .VBLANK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
    int          gap;
    logic        eof;
    logic [15:0] fc;
  } beat_t;

  beat_t       exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          beats   = 0;
  bit          rand_bp = 1'b0;
  logic [15:0] model_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_pix(input int pat, input int x, input int y,
                                            input logic [7:0] fc);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    case (pat)
      0: begin
        case (x / (W / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return {xb, xb, xb};
      2: return (x % 32 == 0 || y % 32 == 0 || x == W - 1 || y == H - 1) ? 24'hFFFFFF : 24'h0;
      default: return {xb, yb, fc};
    endcase
  endfunction

  // Queue one whole frame; first_gap < 0 means the start latency is not checked.
  task automatic push_frame(input int pat, input int first_gap);
    beat_t e;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        e.d   = model_pix(pat, xx, yy, model_fc[7:0]);
        e.u   = (xx == 0 && yy == 0);
        e.l   = (xx == W - 1);
        e.gap = (xx == 0 && yy == 0) ? first_gap : ((xx == 0) ? HB : 0);
        e.eof = (xx == W - 1 && yy == H - 1);
        e.fc  = model_fc + 16'd1;
        exp_q.push_back(e);
      end
    end
    model_fc = model_fc + 16'd1;
  endtask

  // Monitor / scoreboard
  initial begin
    logic        prev_stall, prev_valid, pend_done;
    logic [25:0] prev_out;
    logic [15:0] pend_fc;
    int          idle, first_gap;
    beat_t       e;
    prev_stall = 1'b0; prev_valid = 1'b0; pend_done = 1'b0; pend_fc = '0;
    prev_out = '0; idle = 0; first_gap = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0; prev_valid = 1'b0; pend_done = 1'b0; idle = 0; first_gap = 0;
      end else begin
        chk("frame_done", frame_done, pend_done);
        if (pend_done) chk("frame_cnt", frame_cnt, pend_fc);
        pend_done = 1'b0;
        if (prev_stall) begin
          chk("stall_valid", m_axis_tvalid, 1'b1);
          chk("stall_hold", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, prev_out);
        end
        if (m_axis_tvalid && !prev_valid) begin
          first_gap = idle;
          idle      = 0;
        end else if (!m_axis_tvalid) begin
          idle++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t", m_axis_tdata, $time);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", m_axis_tdata, e.d);
            chk("tuser", m_axis_tuser, e.u);
            chk("tlast", m_axis_tlast, e.l);
            if (e.gap >= 0) chk("idle_gap", first_gap, e.gap);
            pend_done = e.eof;
            pend_fc   = e.fc;
            beats++;
          end
          first_gap = 0;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        prev_valid = m_axis_tvalid;
      end
    end
  end

  // Sink backpressure
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_tests++;
    if (beats < target) begin
      n_fail++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", beats, target);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_tdata", m_axis_tdata, 24'h0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tuser", m_axis_tuser, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    chk("rst_busy", busy, 1'b0);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk({name, "_tvalid"}, m_axis_tvalid, 1'b0);
    chk({name, "_busy"}, busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame(input int pat);
    @(posedge clk);
    #1;
    pattern_sel = 2'(pat);
    enable      = 1'b1;
    push_frame(pat, -1);
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  initial begin
    int base, vcount;
    rst_n = 1'b0;
    enable = 1'b1;
    pattern_sel = 2'd3;
    model_fc = 16'd0;

    // Reset with enable held high, then first frame after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    push_frame(3, -1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_beats(1, 20);
    enable = 1'b0;
    wait_drain(400);
    check_idle("after_rst_frame");

    // Single enable pulse, pattern 3: latency and busy
    pulse_frame(3);
    @(negedge clk);
    chk("first_beat_valid", m_axis_tvalid, 1'b1);
    chk("first_beat_tuser", m_axis_tuser, 1'b1);
    chk("busy_active", busy, 1'b1);
    wait_drain(400);
    check_idle("after_pulse");

    // Same frame under random backpressure
    rand_bp = 1'b1;
    pulse_frame(3);
    wait_drain(1000);
    rand_bp = 1'b0;
    check_idle("after_bp");

    // Colour bars with mid-frame selection change, then grid, then ramp
    base = beats;
    pulse_frame(0);
    wait_beats(base + 10, 100);
    pattern_sel = 2'd2;
    wait_drain(400);
    pulse_frame(2);
    wait_drain(400);
    rand_bp = 1'b1;
    pulse_frame(1);
    wait_drain(1000);
    rand_bp = 1'b0;
    check_idle("after_patterns");

    // Continuous enable: three frames, enable dropped on line 1 of the third
    @(posedge clk);
    #1;
    pattern_sel = 2'd3;
    enable = 1'b1;
    push_frame(3, -1);
    push_frame(3, VB);
    push_frame(3, VB);
    base = beats;
    wait_beats(base + 2 * W * H + 20, 600);
    enable = 1'b0;
    wait_drain(400);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) vcount++;
    end
    chk("no_beats_after_stop", vcount, 0);
    check_idle("after_continuous");

    // Reset mid-frame at beat 20, then a clean restart
    base = beats;
    pulse_frame(3);
    wait_beats(base + 20, 100);
    rst_n  = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset();
    exp_q.delete();
    model_fc = 16'd0;
    push_frame(3, -1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = beats;
    wait_beats(base + 1, 20);
    enable = 1'b0;
    wait_drain(400);
    check_idle("after_midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
